gerador_passo: RTL and testbench

- Upstream stage of the mod-6 counter: produces the single-cycle step pulse the counter consumes, so the counter advances once per valid event instead of on raw mechanical edges.
- Two sources for the step:
  - Manual: a debounced push-button press.
  - Auto: a free-running prescaler tick that can be paused and resumed from the same button.
- Sits between the board pushbutton/switch and the counter's step (clock-enable) input.

---
 rtl/gerador_passo_pkg.sv | 17 +
 rtl/gerador_passo_debouncer.sv | 105 ++++++++++
 rtl/gerador_passo.sv | 117 +++++++++++
 tb/tb_gerador_passo.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/gerador_passo_pkg.sv
// gerador_passo_pkg
// Shared types and limits for the step-pulse generator that feeds the mod-6
// counter.
//   deb_state_t : states of the pushbutton debounce FSM
//   MAX_SYNC    : largest synchroniser depth that gerador_passo accepts
package gerador_passo_pkg;

  typedef enum logic [1:0] {
    LOW_STABLE,
    WAIT_HIGH,
    HIGH_STABLE,
    WAIT_LOW
  } deb_state_t;

  localparam int MAX_SYNC = 4;

endpackage

// File: rtl/gerador_passo_debouncer.sv
// gerador_passo_debouncer
// Brings an asynchronous, bouncy input into the clk domain and accepts a
// level change only after the synchronised input has stayed stable long
// enough. On every accepted low-to-high change it raises a one-cycle press
// event.
// Ports:
//   clk     : system clock, rising edge
//   rst     : asynchronous active-high reset
//   i_raw   : raw asynchronous input
//   o_level : debounced level (registered)
//   o_press : one-cycle event, high in the cycle in which a rising level is
//             accepted, so that a consumer registering it lines up with o_level
module gerador_passo_debouncer
  import gerador_passo_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  output logic o_level,
  output logic o_press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CW-1:0]          r_cnt;
  deb_state_t             r_state;
  logic                   r_level;
  logic                   w_in;
  logic                   w_done;

  // Synchroniser chain; only its last stage is used downstream.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
    end
  end

  assign w_in    = r_sync[SYNC_STAGES-1];
  assign w_done  = (r_cnt == CNT_LAST);
  // The press is decoded from the state that is about to be left, so a step
  // registered from it rises together with o_level.
  assign o_press = (r_state == WAIT_HIGH) && w_in && w_done;
  assign o_level = r_level;

  // Debounce FSM: a WAIT state counts stable samples and falls back to the
  // previous stable state as soon as the input disagrees.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= LOW_STABLE;
      r_cnt   <= '0;
      r_level <= 1'b0;
    end else begin
      case (r_state)
        LOW_STABLE: begin
          if (w_in) begin
            r_cnt   <= '0;
            r_state <= WAIT_HIGH;
          end
        end
        WAIT_HIGH: begin
          if (!w_in) begin
            r_cnt   <= '0;
            r_state <= LOW_STABLE;
          end else if (w_done) begin
            r_cnt   <= '0;
            r_state <= HIGH_STABLE;
            r_level <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        HIGH_STABLE: begin
          if (!w_in) begin
            r_cnt   <= '0;
            r_state <= WAIT_LOW;
          end
        end
        WAIT_LOW: begin
          if (w_in) begin
            r_cnt   <= '0;
            r_state <= HIGH_STABLE;
          end else if (w_done) begin
            r_cnt   <= '0;
            r_state <= LOW_STABLE;
            r_level <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: begin
          r_cnt   <= '0;
          r_state <= LOW_STABLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/gerador_passo.sv
// gerador_passo
// Produces the single-cycle step pulse (clock enable) for the mod-6 counter,
// either from a debounced button press (manual) or from a free-running
// prescaler tick (auto) that the same button pauses and resumes.
// Ports:
//   clk       : system clock, rising edge
//   rst       : asynchronous active-high reset
//   btn_raw   : raw pushbutton, asynchronous and bouncy, active-high
//   auto_mode : 0 = manual step, 1 = auto step (synchronised internally)
//   step      : registered single-cycle step pulse
//   btn_db    : debounced button level
//   paused    : high while auto mode is paused
//   step_led  : toggles on every step pulse
module gerador_passo
  import gerador_passo_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int TICK_DIV        = 50000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  input  logic auto_mode,
  output logic step,
  output logic btn_db,
  output logic paused,
  output logic step_led
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  generate
    if (SYNC_STAGES < 2 || SYNC_STAGES > MAX_SYNC || DEBOUNCE_CYCLES < 1 || TICK_DIV < 2) begin : g_bad_params
      $error("gerador_passo: parameter out of range");
    end
  endgenerate

  logic [SYNC_STAGES-1:0] r_mode_sync;
  logic                   r_mode_prev;
  logic [PW-1:0]          r_presc;
  logic                   r_paused;
  logic                   r_step;
  logic                   r_step_led;
  logic                   w_mode;
  logic                   w_mode_change;
  logic                   w_tick;
  logic                   w_press;
  logic                   w_step_next;

  gerador_passo_debouncer #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk     (clk),
    .rst     (rst),
    .i_raw   (btn_raw),
    .o_level (btn_db),
    .o_press (w_press)
  );

  // The mode switch only needs synchronising; it is quasi-static, so no
  // debounce is applied.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mode_sync <= '0;
    end else begin
      r_mode_sync <= {r_mode_sync[SYNC_STAGES-2:0], auto_mode};
    end
  end

  assign w_mode        = r_mode_sync[SYNC_STAGES-1];
  assign w_mode_change = (w_mode != r_mode_prev);
  assign w_tick        = (r_presc == PRESC_LAST);

  // The old paused value gates the tick, so a press that lands on a tick
  // still lets that tick through before pausing.
  always_comb begin
    w_step_next = 1'b0;
    if (!w_mode_change) begin
      w_step_next = w_mode ? (w_tick && !r_paused) : w_press;
    end
  end

  // Prescaler, pause flag and registered step outputs. A mode change or
  // manual mode keeps the prescaler and pause flag cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mode_prev <= 1'b0;
      r_presc     <= '0;
      r_paused    <= 1'b0;
      r_step      <= 1'b0;
      r_step_led  <= 1'b0;
    end else begin
      r_mode_prev <= w_mode;
      r_step      <= w_step_next;
      r_step_led  <= r_step_led ^ w_step_next;
      if (w_mode_change || !w_mode) begin
        r_presc  <= '0;
        r_paused <= 1'b0;
      end else begin
        if (!r_paused) begin
          r_presc <= w_tick ? '0 : r_presc + PW'(1);
        end
        if (w_press) begin
          r_paused <= !r_paused;
        end
      end
    end
  end

  assign step     = r_step;
  assign paused   = r_paused;
  assign step_led = r_step_led;

endmodule

// File: tb/tb_gerador_passo.sv
// tb_gerador_passo
// Table-driven bench for gerador_passo with small parameters. Each vector
// holds the inputs driven before one rising edge and the outputs expected
// after that edge; vector i therefore corresponds to the (i+1)-th edge after
// the sequence starts. A press applied before edge e is accepted at edge e+6.
module tb_gerador_passo;

  localparam int SYNC_STAGES     = 2;
  localparam int DEBOUNCE_CYCLES = 4;
  localparam int TICK_DIV        = 5;

  logic clk = 1'b0;
  logic rst;
  logic btn_raw;
  logic auto_mode;
  logic step;
  logic btn_db;
  logic paused;
  logic step_led;

  typedef struct {
    logic btn;
    logic mode;
    logic expStep;
    logic expDb;
    logic expPaused;
  } vec_t;

  vec_t  vecs[$];
  int    checks   = 0;
  int    failures = 0;
  logic  ledModel = 1'b0;
  string testName = "init";

  always #5 clk = ~clk;

  gerador_passo #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .TICK_DIV        (TICK_DIV)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_raw   (btn_raw),
    .auto_mode (auto_mode),
    .step      (step),
    .btn_db    (btn_db),
    .paused    (paused),
    .step_led  (step_led)
  );

  // Single comparison with failure reporting.
  task automatic compare(input string what, input int idx, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s %s vec %0d: got %b expected %b", testName, what, idx, got, exp);
    end
  endtask

  task automatic addVec(input logic btn, input logic mode, input logic stp, input logic db, input logic pau);
    vec_t v;
    v.btn       = btn;
    v.mode      = mode;
    v.expStep   = stp;
    v.expDb     = db;
    v.expPaused = pau;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input vec_t v);
    btn_raw   = v.btn;
    auto_mode = v.mode;
  endtask

  task automatic checkOutput(input vec_t v, input int idx);
    if (v.expStep) ledModel = ~ledModel;
    compare("step", idx, step, v.expStep);
    compare("btn_db", idx, btn_db, v.expDb);
    compare("paused", idx, paused, v.expPaused);
    compare("step_led", idx, step_led, ledModel);
  endtask

  // Applies the queued vectors one per cycle, sampling on the falling edge.
  task automatic runTable();
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      @(negedge clk);
      checkOutput(vecs[i], i);
    end
    vecs.delete();
  endtask

  task automatic checkAllZero(input int idx);
    compare("step", idx, step, 1'b0);
    compare("btn_db", idx, btn_db, 1'b0);
    compare("paused", idx, paused, 1'b0);
    compare("step_led", idx, step_led, 1'b0);
  endtask

  task automatic doReset();
    @(negedge clk);
    testName  = "reset";
    rst       = 1'b1;
    btn_raw   = 1'b0;
    auto_mode = 1'b0;
    #1;
    checkAllZero(0);
    repeat (2) @(negedge clk);
    checkAllZero(1);
    rst      = 1'b0;
    ledModel = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst       = 1'b1;
    btn_raw   = 1'b0;
    auto_mode = 1'b0;
    doReset();

    // Manual clean press, held 20 cycles, then released.
    testName = "manual_press";
    for (int i = 0; i < 32; i++)
      addVec(i < 20, 1'b0, i == 6, (i >= 6) && (i <= 25), 1'b0);
    runTable();

    // Button held, accepted, then an asynchronous reset mid-cycle.
    testName = "pre_reset";
    for (int i = 0; i < 9; i++)
      addVec(1'b1, 1'b0, i == 6, i >= 6, 1'b0);
    runTable();
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    testName = "async_reset";
    checkAllZero(0);
    @(negedge clk);
    rst      = 1'b0;
    ledModel = 1'b0;
    testName = "post_reset_held";
    for (int i = 0; i < 12; i++)
      addVec(1'b1, 1'b0, i == 6, i >= 6, 1'b0);
    runTable();

    // Bouncing press: only the final stable rising edge counts.
    doReset();
    testName = "bounce";
    for (int i = 0; i < 24; i++)
      addVec((i < 2) || (i >= 4 && i < 6) || (i >= 8), 1'b0, i == 14, i >= 14, 1'b0);
    runTable();

    // Auto run: first tick 5 edges after the synchronised change, then every 5.
    doReset();
    testName = "auto_run";
    for (int i = 0; i < 33; i++)
      addVec(1'b0, 1'b1, (i >= 7) && ((i - 7) % 5 == 0), 1'b0, 1'b0);
    runTable();

    // Auto pause at prescaler = 2, resume after 3 remaining cycles.
    doReset();
    testName = "pause_resume";
    for (int i = 0; i < 46; i++)
      addVec((i >= 13 && i <= 19) || (i >= 30), 1'b1,
             (i == 7) || (i == 12) || (i == 17) || (i == 39) || (i == 44),
             (i >= 19 && i <= 25) || (i >= 36),
             (i >= 19) && (i <= 35));
    runTable();

    // Mode switch to manual when the prescaler holds 3, then back to auto.
    doReset();
    testName = "mode_switch";
    for (int i = 0; i < 26; i++)
      addVec(1'b0, !(i >= 4 && i <= 10), (i == 18) || (i == 23), 1'b0, 1'b0);
    runTable();

    // Press coinciding with a tick: the tick still goes out, then pause.
    doReset();
    testName = "press_on_tick";
    for (int i = 0; i < 20; i++)
      addVec(i >= 6, 1'b1, (i == 7) || (i == 12), i >= 12, i >= 12);
    runTable();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
